// File: rtl/clock_12h_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_12h_pkg
// Brief    : Shared limits, time record type and helpers for the 12-hour clock
// Revision : 1.0 - initial release
// ============================================================================
package clock_12h_pkg;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [3:0] HOUR_MAX = 4'd12;
   localparam logic [3:0] HOUR_MIN = 4'd1;

   typedef struct packed {
      logic [5:0] sec;
      logic [5:0] min;
      logic [3:0] hour;
      logic       pm;
   } time_t;

   // 12:00:00 AM
   localparam time_t RESET_TIME = '{sec: 6'd0, min: 6'd0, hour: HOUR_MAX, pm: 1'b0};

   // Hour step with 12-hour rules: 11 -> 12 flips AM/PM, 12 -> 1 does not.
   function automatic time_t advance_hour(input time_t t);
      time_t r;
      r = t;
      if (t.hour == HOUR_MAX) begin
         r.hour = HOUR_MIN;
      end else begin
         r.hour = t.hour + 4'd1;
         if (t.hour == (HOUR_MAX - 4'd1)) begin
            r.pm = ~t.pm;
         end
      end
      return r;
   endfunction

   // Modulo-(vmax+1) increment for the seconds and minutes fields.
   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] vmax);
      return (v == vmax) ? 6'd0 : (v + 6'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/clock_12h_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : clock_12h_prescaler
// Brief    : Divides clk into a one-cycle seconds tick while enabled
// Revision : 1.0 - initial release
// ============================================================================
module clock_12h_prescaler
   import clock_12h_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   // A one-tick-per-cycle divider still needs a 1-bit counter to keep widths legal.
   localparam int            CW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] r_cnt;

   // Count 0..TICKS_PER_SEC-1 only while enabled; frozen otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == C_LAST) ? '0 : (r_cnt + CW'(1));
      end
   end

   assign tick = en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/clock_12h.sv
`default_nettype none
// ============================================================================
// Module   : clock_12h
// Brief    : 12-hour HH:MM:SS AM/PM clock tile with hour/minute set buttons
// Revision : 1.0 - initial release
// ============================================================================
module clock_12h
   import clock_12h_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Button vectors: bit 0 = hour advance, bit 1 = minute advance.
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] r_prev;
   logic [1:0] w_press;
   logic       w_tick;
   time_t      r_time;
   time_t      w_next;

   clock_12h_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (ena & ~ui_in[0]),
      .tick (w_tick)
   );

   // Two-flop synchronizer plus edge register; the whole chain freezes with ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
         r_prev  <= 2'b00;
      end else if (ena) begin
         r_sync1 <= ui_in[2:1];
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_press = r_sync2 & ~r_prev & {2{ena}};

   // Next time: button adjusts take priority and swallow a coincident tick.
   always_comb begin
      w_next = r_time;
      if (w_press[0]) begin
         w_next = advance_hour(w_next);
      end
      if (w_press[1]) begin
         w_next.min = wrap_inc(r_time.min, MIN_MAX);
      end
      if ((w_press == 2'b00) && w_tick) begin
         w_next.sec = wrap_inc(r_time.sec, SEC_MAX);
         if (r_time.sec == SEC_MAX) begin
            w_next.min = wrap_inc(r_time.min, MIN_MAX);
            if (r_time.min == MIN_MAX) begin
               w_next = advance_hour(w_next);
            end
         end
      end
   end

   // Time-of-day register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_time <= RESET_TIME;
      end else begin
         r_time <= w_next;
      end
   end

   assign uo_out  = {1'b0, r_time.min[5:4], r_time.pm, r_time.hour};
   assign uio_out = {r_time.min[3:0], r_time.sec[5:2]};
   assign uio_oe  = 8'hFF;

   // Inputs and bits with no function on this tile.
   logic w_unused;
   assign w_unused = &{1'b0, uio_in, ui_in[7:3], r_time.sec[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_clock_12h.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_12h
// Brief    : Self-checking bench for clock_12h (TICKS_PER_SEC = 1 and 4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_12h;

   localparam int TPS [2] = '{1, 4};
   localparam int DAY     = 86400;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo1, uio1, oe1;
   logic [7:0] uo4, uio4, oe4;

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   clock_12h #(.TICKS_PER_SEC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo1),
      .uio_in(uio_in), .uio_out(uio1), .uio_oe(oe1)
   );

   clock_12h #(.TICKS_PER_SEC(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo4),
      .uio_in(uio_in), .uio_out(uio4), .uio_oe(oe4)
   );

   // ---------------- reference model: time as seconds since midnight ----------------
   int       m_t  [2];
   int       m_pc [2];
   bit [2:0] hb;   // hour button samples at previous enabled edges ([0] newest)
   bit [2:0] mb;   // minute button samples

   function automatic logic [7:0] disp_uo(input int t);
      int h24, h12, m;
      logic [5:0] mm;
      logic [3:0] hh;
      h24 = t / 3600;
      h12 = (h24 % 12 == 0) ? 12 : (h24 % 12);
      m   = (t / 60) % 60;
      mm  = 6'(m);
      hh  = 4'(h12);
      return {1'b0, mm[5:4], (h24 >= 12), hh};
   endfunction

   function automatic logic [7:0] disp_uio(input int t);
      logic [5:0] mm, ss;
      mm = 6'((t / 60) % 60);
      ss = 6'(t % 60);
      return {mm[3:0], ss[5:2]};
   endfunction

   function automatic int add_minute(input int t);
      int m;
      m = (t / 60) % 60;
      return t - m * 60 + ((m + 1) % 60) * 60;
   endfunction

   // Model step: presses seen two enabled edges after the input rose; adjust drops tick.
   int  nt, npc;
   bit  hp, mp, tk;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 2; j++) begin
            m_t[j]  <= 0;
            m_pc[j] <= 0;
         end
         hb <= 3'b000;
         mb <= 3'b000;
      end else if (ena) begin
         hp = hb[1] && !hb[2];
         mp = mb[1] && !mb[2];
         for (int j = 0; j < 2; j++) begin
            nt  = m_t[j];
            npc = m_pc[j];
            tk  = 1'b0;
            if (!ui_in[0]) begin
               tk  = (npc % TPS[j]) == (TPS[j] - 1);
               npc = npc + 1;
            end
            if (hp) nt = (nt + 3600) % DAY;
            if (mp) nt = add_minute(nt);
            if (!hp && !mp && tk) nt = (nt + 1) % DAY;
            m_t[j]  <= nt;
            m_pc[j] <= npc;
         end
         hb <= {hb[1:0], ui_in[1]};
         mb <= {mb[1:0], ui_in[2]};
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         check("dut1_uo",  uo1,  disp_uo(m_t[0]));
         check("dut1_uio", uio1, disp_uio(m_t[0]));
         check("dut1_oe",  oe1,  8'hFF);
         check("dut4_uo",  uo4,  disp_uo(m_t[1]));
         check("dut4_uio", uio4, disp_uio(m_t[1]));
         check("dut4_oe",  oe4,  8'hFF);
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press(input int bitn, input int n);
      for (int i = 0; i < n; i++) begin
         ui_in[bitn] = 1'b1;
         step(1);
         ui_in[bitn] = 1'b0;
         step(1);
      end
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      step(10);
      checking = 1'b1;
      check("rst_uo",  uo1,  8'h0C);
      check("rst_uio", uio1, 8'h00);
      check("rst_oe",  oe1,  8'hFF);
      check("rst_model", disp_uo(m_t[0]), 8'h0C);
      rst_n = 1'b1;
      step(60);
      check("min1_uio", uio1, 8'h10);
      check("min1_uo",  uo1,  8'h0C);
      check("t4_15s",   uio4, 8'h03);

      // Mid-count reset clears immediately and restarts at release
      step(440);
      rst_n = 1'b0;
      #1;
      check("midrst_uo",  uo1,  8'h0C);
      check("midrst_uio", uio1, 8'h00);
      step(5);
      rst_n = 1'b1;
      step(4);
      check("restart_uio", uio1, 8'h01);

      // 11:59:xx AM -> 12:00:00 PM
      ui_in[0] = 1'b1;
      press(1, 11);
      press(2, 59);
      step(4);
      check("pre_am_uo", uo1, 8'h6B);
      ui_in[0] = 1'b0;
      step(60 - (m_t[0] % 60));
      check("noon_uo",  uo1,  8'h1C);
      check("noon_uio", uio1, 8'h00);

      // 11:59:xx PM -> 12:00:00 AM
      ui_in[0] = 1'b1;
      press(1, 11);
      press(2, 59);
      step(4);
      check("pre_pm_uo", uo1, 8'h7B);
      ui_in[0] = 1'b0;
      step(60 - (m_t[0] % 60));
      check("midnight_uo",  uo1,  8'h0C);
      check("midnight_uio", uio1, 8'h00);

      // 12:59:xx AM -> 1:00:00 AM, no AM/PM change
      ui_in[0] = 1'b1;
      press(2, 59);
      step(4);
      check("pre_1259_uo", uo1, 8'h6C);
      ui_in[0] = 1'b0;
      step(60 - (m_t[0] % 60));
      check("one_am_uo",  uo1,  8'h01);
      check("one_am_uio", uio1, 8'h00);

      // Hold freezes seconds; hour button still works
      ui_in[0] = 1'b1;
      step(100);
      check("hold_uio", uio1, 8'h00);
      check("hold_uo",  uo1,  8'h01);
      press(1, 1);
      step(4);
      check("hold_hour_uo", uo1, 8'h02);

      // Minute button at 59 wraps without carry; long press counts once
      press(2, 59);
      step(4);
      check("m59_uo",  uo1,  8'h62);
      check("m59_uio", uio1, 8'hB0);
      press(2, 1);
      step(4);
      check("mwrap_uo",  uo1,  8'h02);
      check("mwrap_uio", uio1, 8'h00);
      ui_in[2] = 1'b1;
      step(20);
      ui_in[2] = 1'b0;
      step(4);
      check("longpress_uio", uio1, 8'h10);
      ui_in[0] = 1'b0;

      // ena low freezes everything; divide-by-4 tick rate
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(15);
      ena = 1'b0;
      step(8);
      check("ena_freeze_t4", uio4, 8'h00);
      check("ena_freeze_t1", uio1, 8'h03);
      ena = 1'b1;
      step(4);
      check("ena_resume_t4", uio4, 8'h01);
      check("ena_resume_t1", uio1, 8'h04);

      // Randomized traffic on all inputs
      for (int i = 0; i < 3000; i++) begin
         ui_in[7:3] = 5'($urandom);
         ui_in[0]   = ($urandom_range(0, 3) == 0);
         ui_in[1]   = ($urandom_range(0, 5) == 0);
         ui_in[2]   = ($urandom_range(0, 3) == 0);
         uio_in     = 8'($urandom);
         ena        = ($urandom_range(0, 9) != 0);
         step(1);
      end
      ena = 1'b1;
      ui_in = 8'h00;
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
